scan_io_chain: RTL and testbench

//  Scan register between the TAP wrapper and the core under test (CUT). Clocked by tck.

---
 rtl/scan_pkg.sv | 15 +
 rtl/scan_shift_reg.sv | 40 ++++
 rtl/scan_io_chain.sv | 91 +++++++++
 tb/tb_scan_io_chain.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and constants for the scan I/O chain: FSM encoding and reset values.
package scan_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    SHFT = 2'd2
  } state_t;

  localparam logic RST_PULSE = 1'b0;
  localparam logic RST_BIT   = 1'b0;

endpackage : scan_pkg

// File: rtl/scan_shift_reg.sv
// Serial scan register with a parallel capture port and a saturating shifted-bit counter.
module scan_shift_reg
  import scan_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic             tck,
  input  logic             trst,
  input  logic             shift_en,
  input  logic             cap_en,
  input  logic [N-1:0]     cap_vec,
  input  logic             sin,
  output logic             sout,
  output logic [N-1:0]     sr,
  output logic [CNT_W-1:0] cnt
);

  logic [N-1:0]     sr_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Shift takes priority over capture; the top never asserts both.
  always_ff @(posedge tck) begin
    if (!trst) begin
      sr_reg  <= {N{RST_BIT}};
      cnt_reg <= '0;
    end else if (shift_en) begin
      sr_reg  <= {sin, sr_reg[N-1:1]};
      cnt_reg <= (cnt_reg == CNT_W'(N)) ? cnt_reg : cnt_reg + 1'b1;
    end else if (cap_en) begin
      sr_reg  <= cap_vec;
      cnt_reg <= '0;
    end
  end

  assign sout = sr_reg[0];
  assign sr   = sr_reg;
  assign cnt  = cnt_reg;

endmodule : scan_shift_reg

// File: rtl/scan_io_chain.sv
// Boundary-style scan chain between the TAP wrapper and the core under test:
// capture/shift/update sequencing, update register and core input mux.
module scan_io_chain
  import scan_pkg::*;
#(
  parameter int WIDTH_IN  = 2,
  parameter int WIDTH_OUT = 2
) (
  input  logic                 tck,
  input  logic                 trst,
  input  logic                 test,
  input  logic                 shift,
  input  logic                 sin,
  output logic                 sout,
  input  logic [WIDTH_IN-1:0]  func_in,
  output logic [WIDTH_IN-1:0]  core_in,
  input  logic [WIDTH_OUT-1:0] core_out,
  output logic                 upd_pulse,
  output logic                 short_err
);

  localparam int N     = WIDTH_IN + WIDTH_OUT;
  localparam int CNT_W = $clog2(N + 1);

  state_t              state_reg;
  logic [WIDTH_IN-1:0] ur_reg;
  logic                upd_pulse_reg;
  logic                short_err_reg;
  logic [N-1:0]        sr;
  logic [CNT_W-1:0]    cnt;
  logic                shift_en;
  logic                cap_en;

  assign shift_en = test & shift;
  // The edge that closes a shift burst holds sr so the update sees the shifted data.
  assign cap_en   = test & ~shift & (state_reg != SHFT);

  scan_shift_reg #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_shift_reg (
    .tck      (tck),
    .trst     (trst),
    .shift_en (shift_en),
    .cap_en   (cap_en),
    .cap_vec  ({func_in, core_out}),
    .sin      (sin),
    .sout     (sout),
    .sr       (sr),
    .cnt      (cnt)
  );

  always_ff @(posedge tck) begin
    if (!trst) begin
      state_reg     <= IDLE;
      ur_reg        <= '0;
      upd_pulse_reg <= RST_PULSE;
      short_err_reg <= RST_PULSE;
    end else begin
      upd_pulse_reg <= 1'b0;
      short_err_reg <= 1'b0;
      if (!test) begin
        state_reg <= IDLE;
      end else if (shift) begin
        state_reg <= SHFT;
      end else if (state_reg == SHFT) begin
        // Only a full (or over-length) shift may reach the core inputs.
        if (cnt == CNT_W'(N)) begin
          ur_reg        <= sr[N-1:WIDTH_OUT];
          upd_pulse_reg <= 1'b1;
        end else begin
          short_err_reg <= 1'b1;
        end
        state_reg <= CAPT;
      end else begin
        state_reg <= CAPT;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH_IN; gi++) begin : g_core_in
      assign core_in[gi] = test ? ur_reg[gi] : func_in[gi];
    end
  endgenerate

  assign upd_pulse = upd_pulse_reg;
  assign short_err = short_err_reg;

endmodule : scan_io_chain

// File: tb/tb_scan_io_chain.sv
// Directed bench for scan_io_chain (WIDTH_IN=2, WIDTH_OUT=2): vector table plus abort/reset sequences.
module tb_scan_io_chain;

  logic       tck;
  logic       trst;
  logic       test;
  logic       shift;
  logic       sin;
  logic       sout;
  logic [1:0] func_in;
  logic [1:0] core_in;
  logic [1:0] core_out;
  logic       upd_pulse;
  logic       short_err;

  int n_tests;
  int n_fail;

  scan_io_chain #(
    .WIDTH_IN  (2),
    .WIDTH_OUT (2)
  ) dut (
    .tck       (tck),
    .trst      (trst),
    .test      (test),
    .shift     (shift),
    .sin       (sin),
    .sout      (sout),
    .func_in   (func_in),
    .core_in   (core_in),
    .core_out  (core_out),
    .upd_pulse (upd_pulse),
    .short_err (short_err)
  );

  initial begin
    tck = 1'b0;
    forever #5 tck = ~tck;
  end

  typedef struct packed {
    logic       trst;
    logic       test;
    logic       shift;
    logic       sin;
    logic [1:0] func_in;
    logic [1:0] core_out;
    logic       exp_sout;
    logic [1:0] exp_core_in;
    logic       exp_upd;
    logic       exp_short;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, input logic t, input logic s, input logic si,
                              input logic [1:0] fi, input logic [1:0] co,
                              input logic es, input logic [1:0] eci,
                              input logic eu, input logic esh);
    vec_t v;
    v.trst = r; v.test = t; v.shift = s; v.sin = si;
    v.func_in = fi; v.core_out = co;
    v.exp_sout = es; v.exp_core_in = eci; v.exp_upd = eu; v.exp_short = esh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge tck);
    #1;
  endtask

  task automatic drive(input logic r, input logic t, input logic s, input logic si,
                       input logic [1:0] fi, input logic [1:0] co);
    trst = r; test = t; shift = s; sin = si; func_in = fi; core_out = co;
  endtask

  task automatic chk_all(input string tag, input logic es, input logic [1:0] eci,
                         input logic eu, input logic esh);
    chk({tag, ".sout"}, {7'd0, sout}, {7'd0, es});
    chk({tag, ".core_in"}, {6'd0, core_in}, {6'd0, eci});
    chk({tag, ".upd_pulse"}, {7'd0, upd_pulse}, {7'd0, eu});
    chk({tag, ".short_err"}, {7'd0, short_err}, {7'd0, esh});
    $display("[TB] %s: sout=%b core_in=%b upd=%b short=%b", tag, sout, core_in, upd_pulse, short_err);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    //                 trst test shift sin func  cout   sout core  upd short
    vecs[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0); // reset
    vecs[1]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0); // capture 1001
    vecs[2]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0);
    vecs[3]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0);
    vecs[4]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0);
    vecs[5]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0);
    vecs[6]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b01, 1'b0, 2'b00, 1'b1, 1'b0); // update ur=00
    vecs[7]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0); // recapture
    vecs[8]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0);
    vecs[9]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0);
    vecs[10] = mk(1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0);
    vecs[11] = mk(1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0);
    vecs[12] = mk(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b01, 1'b0, 2'b11, 1'b1, 1'b0); // update ur=11
    vecs[13] = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 2'b01, 1'b0, 1'b0); // test exit
    vecs[14] = mk(1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b10, 1'b0, 2'b11, 1'b0, 1'b0); // capture 0110
    vecs[15] = mk(1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 2'b10, 1'b1, 2'b11, 1'b0, 1'b0);
    vecs[16] = mk(1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 2'b10, 1'b1, 2'b11, 1'b0, 1'b0);
    vecs[17] = mk(1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 2'b10, 1'b0, 2'b11, 1'b0, 1'b0);
    vecs[18] = mk(1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b10, 1'b0, 2'b11, 1'b0, 1'b1); // short shift
    vecs[19] = mk(1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b10, 1'b0, 2'b11, 1'b0, 1'b0); // capture 0110
    vecs[20] = mk(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 2'b11, 1'b0, 1'b0); // over-shift x5
    vecs[21] = mk(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 2'b11, 1'b0, 1'b0);
    vecs[22] = mk(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 2'b11, 1'b0, 1'b0);
    vecs[23] = mk(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 2'b11, 1'b0, 1'b0);
    vecs[24] = mk(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 2'b11, 1'b0, 1'b0);
    vecs[25] = mk(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b01, 1'b1, 1'b0); // update ur=01

    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].trst, vecs[i].test, vecs[i].shift, vecs[i].sin, vecs[i].func_in, vecs[i].core_out);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].exp_sout, vecs[i].exp_core_in,
              vecs[i].exp_upd, vecs[i].exp_short);
    end

    // Abort: test drops after two shift cycles; ur (01) must survive, no pulses.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b11); step(); chk_all("abort.cap", 1'b1, 2'b01, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b11); step(); chk_all("abort.sh1", 1'b1, 2'b01, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b11); step(); chk_all("abort.sh2", 1'b0, 2'b01, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b11); step(); chk_all("abort.drop", 1'b0, 2'b10, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b11); step(); chk_all("abort.idle", 1'b0, 2'b10, 1'b0, 1'b0);
    // Re-entry recaptures (1101) and restarts the count: 3 shifts must give a short error.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 2'b01); step(); chk_all("reent.cap", 1'b1, 2'b01, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 2'b01); step(); chk_all("reent.sh1", 1'b0, 2'b01, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 2'b01); step(); chk_all("reent.sh2", 1'b1, 2'b01, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 2'b01); step(); chk_all("reent.sh3", 1'b1, 2'b01, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 2'b01); step(); chk_all("reent.end", 1'b1, 2'b01, 1'b0, 1'b1);

    // Reset on the second shift cycle clears sr and ur.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 2'b11); step(); chk_all("rst.cap", 1'b1, 2'b01, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 2'b11); step(); chk_all("rst.sh1", 1'b1, 2'b01, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 2'b11); step(); chk_all("rst.mid", 1'b0, 2'b00, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 2'b10); step(); chk_all("rst.after", 1'b0, 2'b00, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 2'b10); step(); chk_all("rst.cap2", 1'b0, 2'b00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_scan_io_chain
